// File: rtl/conv_pkg.sv
// Shared definitions for the rate-1/2, K=3 convolutional encoder.
// Generators are g0 = 7 (octal) and g1 = 5 (octal). The symbol is {g0, g1}.
package conv_pkg;

  localparam int         CONV_K  = 3;
  localparam logic [2:0] CONV_G0 = 3'b111;
  localparam logic [2:0] CONV_G1 = 3'b101;

  typedef logic [1:0] conv_sym_t;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    TAIL = 1'b1
  } conv_state_e;

  // Taps are ordered {d(n), d(n-1), d(n-2)} = {d, s[1], s[0]}.
  function automatic conv_sym_t conv_sym(input logic d, input logic [1:0] s);
    logic [CONV_K-1:0] taps;
    taps     = {d, s};
    conv_sym = {^(taps & CONV_G0), ^(taps & CONV_G1)};
  endfunction

endpackage

// File: rtl/sym_fifo.sv
// Symbol FIFO with a fixed width of 2 bits and a power-of-2 depth.
// The pointers carry one extra wrap bit. Full means the MSBs differ and the
// index bits match. Empty means the pointers are equal.
// rdata is the head entry, read straight from the storage register.
module sym_fifo
  import conv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  conv_sym_t wdata,
  output conv_sym_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  conv_sym_t   mem_q [DEPTH];
  conv_sym_t   mem_d [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  // Next-state for the storage and both pointers. A push and a pop in the
  // same cycle leave the occupancy unchanged.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    if (do_push) begin
      mem_d[wptr_q[AW-1:0]] = wdata;
      wptr_d                = wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  // Storage and pointer registers. Reset discards all contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2, constraint-length-3 convolutional encoder with an output symbol FIFO.
// Optional feature macro: CONV_ENC_TAIL_EN.
//   Defined:   two zero tail bits are appended after every FRAME_LEN data bits,
//              so each frame ends in state 00.
//   Undefined: the stream is continuous, and frame_done marks every FRAME_LEN data bits.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
// in_ready depends only on FIFO full and the FSM state, never on the same-cycle pop.
// out_valid is simply "FIFO not empty".
// dbg_state and dbg_s expose the FSM state and the shift register for observation.
module conv_encoder
  import conv_pkg::*;
#(
  parameter int FRAME_LEN  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_bit,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [1:0]  out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_done,
  output conv_state_e dbg_state,
  output logic [1:0]  dbg_s
);

  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  logic [1:0]  s_q, s_d;
  logic [15:0] cnt_q, cnt_d;
  logic        fd_q, fd_d;
  logic        full;
  logic        empty;
  logic        push;
  logic        enc_d;
  conv_sym_t   sym;

`ifdef CONV_ENC_TAIL_EN
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_TAIL = 1'b1;

  logic [0:0] state_q, state_d;
  logic       tcnt_q, tcnt_d;

  // Accept and push decode. TAIL pushes zeros on its own while input is held off.
  always_comb begin
    in_ready = (state_q == ST_RUN) && !full;
    push     = 1'b0;
    enc_d    = 1'b0;
    if (state_q == ST_RUN) begin
      push  = in_valid && !full;
      enc_d = in_bit;
    end else begin
      push  = !full;
      enc_d = 1'b0;
    end
  end

  // Shift register, counter and FSM next-state. All of them advance only on a push.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    s_d     = s_q;
    fd_d    = 1'b0;
    if (push) begin
      s_d = {enc_d, s_q[1]};
      if (state_q == ST_RUN) begin
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = ST_TAIL;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end else begin
        if (tcnt_q) begin
          tcnt_d  = 1'b0;
          state_d = ST_RUN;
          fd_d    = 1'b1;
        end else begin
          tcnt_d = 1'b1;
        end
      end
    end
  end

  // FSM and tail counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      tcnt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign dbg_state = conv_state_e'(state_q);
`else
  // Accept and push decode. The stream is continuous and only FIFO full stalls it.
  always_comb begin
    in_ready = !full;
    push     = in_valid && !full;
    enc_d    = in_bit;
  end

  // Shift register and frame counter next-state. frame_done marks each FRAME_LEN-th push.
  always_comb begin
    cnt_d = cnt_q;
    s_d   = s_q;
    fd_d  = 1'b0;
    if (push) begin
      s_d = {enc_d, s_q[1]};
      if (cnt_q == LAST_IDX) begin
        cnt_d = '0;
        fd_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  assign dbg_state = RUN;
`endif

  assign sym = conv_sym(enc_d, s_q);

  // Shift register, bit counter and the registered frame_done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_q   <= 2'b00;
      cnt_q <= '0;
      fd_q  <= 1'b0;
    end else begin
      s_q   <= s_d;
      cnt_q <= cnt_d;
      fd_q  <= fd_d;
    end
  end

  sym_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (out_ready && !empty),
    .wdata (sym),
    .rdata (out),
    .full  (full),
    .empty (empty)
  );

  assign out_valid  = !empty;
  assign frame_done = fd_q;
  assign dbg_s      = s_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Testbench for conv_encoder with FRAME_LEN=4 and FIFO_DEPTH=4.
// Expectations follow CONV_ENC_TAIL_EN in the same way as the design.
module tb_conv_encoder;
  import conv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_bit;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  out;
  logic        out_valid;
  logic        out_ready;
  logic        frame_done;
  conv_state_e dbg_state;
  logic [1:0]  dbg_s;

  int tests_run    = 0;
  int tests_failed = 0;

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  conv_encoder #(
    .FRAME_LEN  (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_bit     (in_bit),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out        (out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .dbg_state  (dbg_state),
    .dbg_s      (dbg_s)
  );

  typedef struct {
    logic       v;
    logic       b;
    logic       exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_out;
    logic       exp_fd;
  } vec_t;

  vec_t       vecs[8];
  logic [1:0] exp_q[$];
  logic [1:0] got_q[$];
  logic       sent_q[$];
  logic [1:0] m_s;
  int         m_cnt;
  bit         mon_en    = 1'b0;
  bit         rnd_ready = 1'b0;
  int         fd_count  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic v, input logic b, input logic rdy,
                         input logic ov, input logic [1:0] o, input logic fd);
    vecs[i].v       = v;
    vecs[i].b       = b;
    vecs[i].exp_rdy = rdy;
    vecs[i].exp_ov  = ov;
    vecs[i].exp_out = o;
    vecs[i].exp_fd  = fd;
  endtask

  // Reference stream model. It encodes the accepted bits and appends the tail symbols.
  task automatic model_push(input logic d);
    exp_q.push_back({d ^ m_s[1] ^ m_s[0], d ^ m_s[0]});
    m_s = {d, m_s[1]};
    m_cnt++;
    if (m_cnt == 4) begin
      m_cnt = 0;
`ifdef CONV_ENC_TAIL_EN
      repeat (2) begin
        exp_q.push_back({m_s[1] ^ m_s[0], m_s[0]});
        m_s = {1'b0, m_s[1]};
      end
`endif
    end
  endtask

  // Scoreboard. Each pop is compared against the front of the expected queue.
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_count++;
    if (mon_en && out_valid === 1'b1 && out_ready === 1'b1) begin
      got_q.push_back(out);
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL pop_order: got %0h, expected queue empty", out);
      end else begin
        check("pop_order", out, exp_q.pop_front());
      end
    end
  end

  // Random downstream readiness for the loopback run.
  always @(posedge clk) begin
    if (rnd_ready) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Returns at posedge+1 with all inputs idle.
  task automatic do_reset();
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    got_q.delete();
    sent_q.delete();
    m_s      = 2'b00;
    m_cnt    = 0;
    fd_count = 0;
  endtask

  // Starts at posedge+1, holds the bit until it is accepted, and returns at posedge+1.
  task automatic send_bit(input logic b);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_bit   = b;
    for (int k = 0; k < 40 && !done; k++) begin
      #2;
      if (in_ready === 1'b1) begin
        model_push(b);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_empty"}, out_valid, 1'b0);
  endtask

  initial begin
    logic [1:0] s;
    logic       d;
    int         k;
    int         acc;
    logic       bp_bits[4];

    // Reset values.
    do_reset();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out", out, 2'b00);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_state", dbg_state, RUN);
    check("rst_s", dbg_s, 2'b00);

    // Basic frame: bits 1,0,1,1, then either the tail or continuing data.
    set_vec(0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0);
    set_vec(1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0);
    set_vec(2, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
`ifdef CONV_ENC_TAIL_EN
    set_vec(3, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0);
    set_vec(4, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0);
    set_vec(5, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1'b1);
    set_vec(6, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0);
    set_vec(7, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
`else
    set_vec(3, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1);
    set_vec(4, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0);
    set_vec(5, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
    set_vec(6, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    set_vec(7, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = vecs[i].v;
      in_bit   = vecs[i].b;
      #2;
      check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].exp_rdy);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_ov);
      if (vecs[i].exp_ov) check($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
      check($sformatf("vec%0d_frame_done", i), frame_done, vecs[i].exp_fd);
    end
`ifdef CONV_ENC_TAIL_EN
    check("frame_end_s", dbg_s, 2'b00);
`else
    check("frame_end_s", dbg_s, 2'b10);
`endif
    check("frame_end_state", dbg_state, RUN);

    // Backpressure: the FIFO fills, out is held stable, then drains in order.
    do_reset();
    bp_bits[0] = 1'b1;
    bp_bits[1] = 1'b0;
    bp_bits[2] = 1'b1;
    bp_bits[3] = 1'b1;
    acc = 0;
    in_valid = 1'b1;
    for (int j = 0; j < 10; j++) begin
      in_bit = bp_bits[acc % 4];
      #2;
      if (in_ready !== 1'b1) break;
      model_push(in_bit);
      acc++;
      @(posedge clk);
      #1;
    end
    check("bp_accepts", acc, 4);
    check("bp_in_ready_low", in_ready, 1'b0);
    @(posedge clk);
    #1;
    for (int j = 0; j < 3; j++) begin
      check("bp_out_hold", out, 2'b11);
      check("bp_valid_hold", out_valid, 1'b1);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    mon_en    = 1'b1;
    out_ready = 1'b1;
    drain("bp");
`ifdef CONV_ENC_TAIL_EN
    check("bp_pop_count", got_q.size(), 6);
`else
    check("bp_pop_count", got_q.size(), 4);
`endif
    check("bp_frame_done_once", fd_count, 1);
    mon_en = 1'b0;

    // Simultaneous push and pop with two entries held in the FIFO.
    do_reset();
    mon_en = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    out_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      in_valid = 1'b1;
      in_bit   = 1'($urandom_range(0, 1));
      #2;
      check("pp_out_valid", out_valid, 1'b1);
`ifndef CONV_ENC_TAIL_EN
      check("pp_in_ready", in_ready, 1'b1);
`endif
      if (in_ready === 1'b1) model_push(in_bit);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
`ifndef CONV_ENC_TAIL_EN
    check("pp_occupancy", exp_q.size(), 2);
`endif
    drain("pp");
    mon_en = 1'b0;

    // Reset mid-frame: the FIFO and the partial frame are discarded.
    do_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_s", dbg_s, 2'b00);
    @(posedge clk);
    #1 reset = 1'b1;
    m_s   = 2'b00;
    m_cnt = 0;
    exp_q.delete();
    send_bit(1'b1);
    in_valid = 1'b0;
    check("mid_rst_restart_valid", out_valid, 1'b1);
    check("mid_rst_restart_sym", out, 2'b11);
    check("mid_rst_restart_s", dbg_s, 2'b10);

    // Loopback: 64 random bits, random downstream stalls, then an inline decoder.
    do_reset();
    mon_en    = 1'b1;
    rnd_ready = 1'b1;
    for (int j = 0; j < 64; j++) begin
      d = 1'($urandom_range(0, 1));
      sent_q.push_back(d);
      send_bit(d);
    end
    in_valid = 1'b0;
    rnd_ready = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain("lb");
    mon_en = 1'b0;
`ifdef CONV_ENC_TAIL_EN
    check("lb_sym_count", got_q.size(), 96);
`else
    check("lb_sym_count", got_q.size(), 64);
`endif
    s = 2'b00;
    k = 0;
    for (int j = 0; j < got_q.size(); j++) begin
      d = got_q[j][0] ^ s[0];
      check("lb_g0_consistent", got_q[j][1], d ^ s[1] ^ s[0]);
`ifdef CONV_ENC_TAIL_EN
      if ((j % 6) >= 4) begin
        check("lb_tail_zero", d, 1'b0);
      end else if (k < sent_q.size()) begin
        check("lb_bit", d, sent_q[k]);
        k++;
      end
`else
      if (k < sent_q.size()) begin
        check("lb_bit", d, sent_q[k]);
        k++;
      end
`endif
      s = {d, s[1]};
    end
    check("lb_decoded_count", k, 64);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/conv_encoder.md
# conv_encoder

Rate-1/2, constraint-length-3 convolutional encoder that produces the 2-bit symbol stream consumed by `decoder`. It accepts one data bit per handshake and appends two zero tail bits after every `FRAME_LEN` data bits, so each frame ends in state 0. Symbols are buffered in a small FIFO and leave on a valid/ready interface toward the channel/decoder side.

## Interface
Parameters:
- `FRAME_LEN`, default 32: data bits per frame; legal range 1..65535.
- `FIFO_DEPTH`, default 4: symbol FIFO entries; must be a power of 2 and at least 2.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `in_bit`  in  1: data bit.
- `in_valid`  in  1: `in_bit` is valid.
- `in_ready`  out  1: encoder accepts `in_bit` this cycle.
- `out`  out  2: coded symbol; `out[1]` = g0 (octal 7), `out[0]` = g1 (octal 5).
- `out_valid`  out  1: `out` holds a valid symbol.
- `out_ready`  in  1: downstream takes `out` this cycle.
- `frame_done`  out  1: one-cycle pulse when the last symbol of a frame enters the FIFO.

## Operation
- **Shift register** `s[1:0]`: `s[1]` holds d(n-1) and `s[0]` holds d(n-2).
  - Symbol: g0 = d ^ s[1] ^ s[0]; g1 = d ^ s[0].
  - Next state: s = {d, s[1]}.
- **FSM states:**
  - RUN: `in_ready` = !fifo_full. Each accepted bit is encoded and pushed, and the bit counter increments. When the accepted bit is number `FRAME_LEN`, the counter clears and the FSM goes to TAIL.
  - TAIL: encodes d = 0 whenever !fifo_full and `in_ready` = 0. The tail counter runs 0 to 1. After the second tail push, s = 00, `frame_done` pulses, and the FSM returns to RUN.
- **Push rule:** at most one symbol is pushed per cycle. The shift register advances only on a push, so the encoder never drops a symbol.
- **Pop rule:** a pop occurs when `out_valid` && `out_ready`. `out` is the FIFO head, taken directly from the storage register.
- **Full/empty:**
  - `in_ready` depends on full only, not on the same-cycle pop, so there is no ready-through path.
  - Push and pop in the same cycle are legal when not full, and occupancy is unchanged.
  - `out_valid` = !empty.
- **Wrap:** read and write pointers are log2(`FIFO_DEPTH`)+1 bits wide.
  - full = MSBs differ and LSBs are equal.
  - empty = pointers are equal.
- **Counter widths:**
  - Bit counter: 16 bits; it compares equal to `FRAME_LEN`-1 on the last bit.
  - Tail counter: 1 bit.
- **Reset:** an assertion mid-frame discards the FIFO contents and the partial frame. There is no recovery of an in-flight frame.

## Timing
- **Reset values:**
  - Outputs: `in_ready` = 1, `out_valid` = 0, `out` = 2'b00, `frame_done` = 0.
  - Internal: FSM = RUN, s = 00, counters = 0, pointers = 0.
- **Latency:** a bit accepted at edge N gives `out_valid` = 1 after edge N when the FIFO was empty. This is one cycle of latency.
- **Throughput:**
  - One symbol per cycle with continuous valid/ready.
  - A frame costs `FRAME_LEN`+2 cycles; `in_ready` is low for the 2 TAIL cycles.
- **`frame_done`:** registered, high for exactly the cycle after the final push. It asserts once per frame even if the downstream stalls.
- **Backpressure:** if `out_ready` is held low, `in_ready` drops after `FIFO_DEPTH` pushes. `out` is held stable while `out_valid` && !`out_ready`.

## Configuration
- **`CONV_ENC_TAIL_EN` defined:** TAIL state and tail counter are present, and frames terminate in s = 00 as described above.
- **`CONV_ENC_TAIL_EN` undefined:**
  - No TAIL state and no tail insertion.
  - The shift register is never cleared between frames, so the stream is continuous.
  - `frame_done` pulses the cycle after the `FRAME_LEN`th data push.
  - `in_ready` is never deasserted except by FIFO full.

## Structure
- **Package `conv_pkg`:**
  - `CONV_K` = 3.
  - `CONV_G0` = 3'b111 and `CONV_G1` = 3'b101.
  - Symbol typedef `conv_sym_t` (logic [1:0]).
  - FSM enum `conv_state_e` {RUN, TAIL}.
  - Function `conv_sym(d, s)` returning the symbol.
- **Sub-module `sym_fifo`:** parameterised by depth, width fixed at 2. Ports: push, pop, wdata, rdata, full, empty. The encoder instantiates one.

## Test plan
- **Basic frame:** `FRAME_LEN`=4, bits 1,0,1,1 back-to-back, `out_ready`=1 -> symbols 11,10,00,01 then tail 01,11. `frame_done` pulses once, and s = 00 afterwards.
- **Backpressure:** `FIFO_DEPTH`=4, `out_ready`=0, `in_valid`=1 -> `in_ready` low after 4 accepts. Releasing `out_ready` then drains the FIFO in order with no loss or duplication.
- **Simultaneous push/pop:** FIFO at depth 2 with `in_valid`=1 and `out_ready`=1 for 20 cycles -> occupancy stays at 2 and the order is preserved.
- **Reset mid-frame:** after 2 of 4 bits, pulse `reset` low -> `out_valid`=0 and `in_ready`=1 immediately. The next bit 1 produces 11, so the encoder has restarted from zero state.
- **Macro off:** `FRAME_LEN`=4, bits 1,0,1,1,0 -> symbols 11,10,00,01,01 with no tail. `frame_done` pulses after the 4th bit.
- **Loopback:** a 64-bit random stream through `conv_encoder` -> `decoder` with no channel errors reproduces the input bits.
